// File: rtl/mips_cache_pkg.sv
// Shared types and defaults for the MIPS cache store path.
package mips_cache_pkg;

   localparam int unsigned WB_BUF_BITS = 3;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  byteenable;
   } wb_entry_t;

endpackage

// File: rtl/mips_wb_fifo.sv
// In-order entry FIFO for the write buffer: storage, wrapping pointers and
// registered occupancy count.
module mips_wb_fifo
   import mips_cache_pkg::*;
#(
   parameter int unsigned BUF_BITS = WB_BUF_BITS
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t wr_entry,
   output wb_entry_t rd_entry,
   output logic      full,
   output logic      empty
);

   localparam int unsigned DEPTH = 1 << BUF_BITS;

   wb_entry_t           mem [DEPTH];
   logic [BUF_BITS-1:0] rd_ptr;
   logic [BUF_BITS-1:0] wr_ptr;
   logic [BUF_BITS:0]   count;
   logic                do_push;
   logic                do_pop;

   // Qualify with the pre-edge flags: a push while full is dropped even if a pop frees a slot.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + BUF_BITS'(1);
         if (do_pop)  rd_ptr <= rd_ptr + BUF_BITS'(1);
         if (do_push && !do_pop)
            count <= count + (BUF_BITS+1)'(1);
         else if (do_pop && !do_push)
            count <= count - (BUF_BITS+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   assign rd_entry = mem[rd_ptr];
   assign full     = (count == (BUF_BITS+1)'(DEPTH));
   assign empty    = (count == '0);

endmodule

// File: rtl/mips_cache_writebuffer.sv
// Store write buffer draining to an Avalon-MM master port.
// Define MIPS_WB_ASSERT_EN to include simulation protocol checks.
module mips_cache_writebuffer
   import mips_cache_pkg::*;
#(
   parameter int unsigned BUF_BITS = WB_BUF_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        write_en,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   input  logic        waitrequest,
   output logic [31:0] write_addr,
   output logic [31:0] write_data,
   output logic [3:0]  write_byteenable,
   output logic        write_writeenable,
   output logic        full,
   output logic        empty
);

   wb_entry_t wr_entry;
   wb_entry_t head;

   assign wr_entry.addr       = addr;
   assign wr_entry.data       = writedata;
   assign wr_entry.byteenable = byteenable;

   mips_wb_fifo #(
      .BUF_BITS (BUF_BITS)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst),
      .push     (write_en),
      .pop      (write_writeenable && !waitrequest),
      .wr_entry (wr_entry),
      .rd_entry (head),
      .full     (full),
      .empty    (empty)
   );

   // Storage is never reset, so the head is masked to keep the bus quiet while empty.
   assign write_writeenable = !empty;
   assign write_addr        = empty ? '0 : head.addr;
   assign write_data        = empty ? '0 : head.data;
   assign write_byteenable  = empty ? '0 : head.byteenable;

`ifdef MIPS_WB_ASSERT_EN
   logic [67:0] bus_vec;
   assign bus_vec = {write_addr, write_data, write_byteenable};

   a_no_push_when_full : assert property (
      @(posedge clk) disable iff (!rst) !(write_en && full))
      else $error("write buffer: write_en asserted while full");

   a_stall_stable : assert property (
      @(posedge clk) disable iff (!rst)
      (write_writeenable && waitrequest) |=> $stable(bus_vec))
      else $error("write buffer: bus outputs changed during waitrequest");
`endif

endmodule

// File: tb/tb_mips_cache_writebuffer.sv
// Scoreboard bench for mips_cache_writebuffer with a queue-based reference model.
module tb_mips_cache_writebuffer;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        write_en;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] write_addr;
   logic [31:0] write_data;
   logic [3:0]  write_byteenable;
   logic        write_writeenable;
   logic        full;
   logic        empty;

   ent_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          pops = 0;
   int          accepts = 0;
   logic [31:0] mem [0:15];
   logic        slave_mode = 1'b0;
   logic        wr_force = 1'b1;
   int          scnt = 0;

   mips_cache_writebuffer dut (
      .clk               (clk),
      .rst               (rst),
      .addr              (addr),
      .write_en          (write_en),
      .writedata         (writedata),
      .byteenable        (byteenable),
      .waitrequest       (waitrequest),
      .write_addr        (write_addr),
      .write_data        (write_data),
      .write_byteenable  (write_byteenable),
      .write_writeenable (write_writeenable),
      .full              (full),
      .empty             (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Slave side: either a forced waitrequest level or a memory that stalls each write two cycles.
   initial begin
      waitrequest = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (slave_mode) begin
            if (write_writeenable && scnt < 2) begin
               waitrequest = 1'b1;
               scnt++;
            end else if (write_writeenable) begin
               waitrequest = 1'b0;
               scnt = 0;
            end else begin
               waitrequest = 1'b1;
            end
         end else begin
            waitrequest = wr_force;
         end
      end
   end

   // Monitor: compare bus against the model head, then retire/enqueue per the rules for this edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            int   occ;
            ent_t e;
            logic [31:0] idx;
            occ = exp_q.size();
            chk("wen", write_writeenable, occ != 0);
            chk("full", full, occ == 8);
            chk("empty", empty, occ == 0);
            if (occ > 0) begin
               chk("head_addr", write_addr, exp_q[0].a);
               chk("head_data", write_data, exp_q[0].d);
               chk("head_be", write_byteenable, exp_q[0].be);
            end else begin
               chk("idle_addr", write_addr, 32'h0);
               chk("idle_data", write_data, 32'h0);
               chk("idle_be", write_byteenable, 32'h0);
            end
            if (occ > 0 && !waitrequest) begin
               idx = write_addr - 32'hBFC0_0000;
               if (idx < 16) mem[idx[3:0]] = write_data;
               void'(exp_q.pop_front());
               pops++;
            end
            if (write_en && occ < 8) begin
               e.a  = addr;
               e.d  = writedata;
               e.be = byteenable;
               exp_q.push_back(e);
               accepts++;
            end
         end
      end
   end

   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic wr);
      write_en   = we;
      addr       = a;
      writedata  = d;
      byteenable = be;
      wr_force   = wr;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (!empty && n < 200) begin
         step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
         n++;
      end
      chk(nm, empty, 1'b1);
   endtask

   initial begin
      int p0;
      int a0;
      for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
      rst = 1'b1;
      write_en = 1'b0;
      addr = '0;
      writedata = '0;
      byteenable = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_wen", write_writeenable, 1'b0);
      chk("rst_addr", write_addr, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Fill under stall, then one dropped push.
      for (int i = 0; i < 8; i++)
         step(1'b1, 32'hBFC0_0000 + i, i * i, 4'hF, 1'b1);
      chk("fill_full", full, 1'b1);
      step(1'b1, 32'hDEAD_0000, 32'h99, 4'hF, 1'b1);
      chk("drop_full", full, 1'b1);
      chk("drop_head_addr", write_addr, 32'hBFC0_0000);
      chk("drop_head_data", write_data, 32'h0);

      // Retire two entries, then hold the third under stall.
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
         chk("stall_addr", write_addr, 32'hBFC0_0002);
         chk("stall_data", write_data, 32'h4);
         chk("stall_wen", write_writeenable, 1'b1);
      end

      // Drain into the slow memory slave.
      slave_mode = 1'b1;
      begin
         int n;
         n = 0;
         while (!empty && n < 200) begin
            step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
            n++;
         end
      end
      slave_mode = 1'b0;
      chk("mem_drain_empty", empty, 1'b1);
      for (int i = 0; i < 8; i++) chk("mem_word", mem[i], i * i);
      chk("mem_dropped_untouched", mem[8], 32'hFFFF_FFFF);

      // Simultaneous push and pop at occupancy 3.
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h2000 + 4 * i, 32'hA0 + i, 4'h3, 1'b1);
      step(1'b1, 32'h200C, 32'hA3, 4'hC, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      p0 = pops;
      drain("simul_drain");
      chk("simul_count", pops - p0, 3);

      // Push/pop a dozen entries so both pointers wrap.
      p0 = pops;
      a0 = accepts;
      for (int i = 0; i < 12; i++)
         step(1'b1, 32'h3000 + 4 * i, 32'h5000 + i, 4'(i), (i % 4) == 3);
      drain("wrap_drain");
      chk("wrap_accepts", accepts - a0, 12);
      chk("wrap_pops", pops - p0, 12);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2) != 0);
      drain("rand_drain");
      chk("rand_balance", pops, accepts);

      // Reset mid-transfer, asserted between clock edges.
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h4000 + i, 32'h77 + i, 4'hF, 1'b1);
      write_en = 1'b0;
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_full", full, 1'b0);
      chk("mid_rst_wen", write_writeenable, 1'b0);
      chk("mid_rst_addr", write_addr, 32'h0);
      chk("mid_rst_data", write_data, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      chk("post_rst_empty", empty, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mips_cache_writebuffer.md
MIPS_CACHE_WRITEBUFFER -- requirements
Module: mips_cache_writebuffer

Interface
REQ-001 SHALL have parameter BUF_BITS, default 3, log2 of entry depth (depth = 2^BUF_BITS = 8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port addr  input  32  byte address of the store to enqueue.
REQ-005 SHALL have port write_en  input  1  enqueue request.
REQ-006 SHALL have port writedata  input  32  store data.
REQ-007 SHALL have port byteenable  input  4  store byte lanes.
REQ-008 SHALL have port waitrequest  input  1  Avalon slave stall.
REQ-009 SHALL have port write_addr  output  32  Avalon address of head entry.
REQ-010 SHALL have port write_data  output  32  Avalon writedata of head entry.
REQ-011 SHALL have port write_byteenable  output  4  Avalon byteenable of head entry.
REQ-012 SHALL have port write_writeenable  output  1  Avalon write strobe.
REQ-013 SHALL have port full  output  1  all entries occupied.
REQ-014 SHALL have port empty  output  1  no entries occupied.

Function
REQ-015 SHALL be an in-order FIFO of {addr, writedata, byteenable} entries; count width BUF_BITS+1.
REQ-016 SHALL accept a push on a rising edge where write_en=1 and full=0; write_en while full=1 is dropped, state unchanged.
REQ-017 SHALL drive write_writeenable=!empty combinationally; write_addr/write_data/write_byteenable = head entry, all zero when empty.
REQ-018 SHALL pop the head on a rising edge where write_writeenable=1 and waitrequest=0; while waitrequest=1 all write_* outputs stay stable.
REQ-019 SHALL, on simultaneous push and pop (full=0), perform both; count unchanged.
REQ-020 SHALL not push while full even if a pop occurs the same cycle (full is the pre-edge value).
REQ-021 SHALL wrap read and write pointers modulo 2^BUF_BITS.
REQ-022 SHALL derive full (count==2^BUF_BITS) and empty (count==0) from registered count, glitch-free, visible the cycle after the causing edge.
REQ-023 SHALL issue entries to the bus in exactly push order with no reordering or merging.

Reset
REQ-024 SHALL, while rst=0, immediately clear pointers and count: empty=1, full=0, write_writeenable=0, write_* data outputs 0.
REQ-025 SHALL discard all pending entries on reset, including one mid-transfer.
REQ-026 SHALL not require entry storage itself to be reset.

Configuration
REQ-027 SHALL, with macro MIPS_WB_ASSERT_EN defined, include simulation checks: error on write_en=1 while full=1, error if write_* outputs change while write_writeenable=1 and waitrequest=1.
REQ-028 SHALL, without MIPS_WB_ASSERT_EN, contain no checks; datapath behaviour identical in both builds.

Structure
REQ-029 SHALL take entry typedef (struct addr/data/byteenable) and default BUF_BITS constant from shared package mips_cache_pkg.
REQ-030 SHALL implement storage/pointers in one sub-module mips_wb_fifo; top level adds Avalon mapping and checks.

Verification
REQ-031 Reset: rst low mid-run -> empty=1, full=0, write_writeenable=0 without waiting for clk.
REQ-032 Fill: waitrequest=1, push 8 entries addr 0xBFC00000+i, data i*i, byteenable 4'b1111 -> full=1 after 8th; 9th push dropped, head still 0xBFC00000/0.
REQ-033 Drain against 2-cycle-delay memory slave: entries written in order, memory word i reads i*i, empty=1 after last pop.
REQ-034 Stall hold: waitrequest=1 for 3 cycles with head 0xBFC00002 -> write_addr/write_data constant, no pop.
REQ-035 Simultaneous: count=3, write_en=1 and waitrequest=0 same edge -> count stays 3, new entry at tail.
REQ-036 Wrap: push/pop 12 entries through 8-deep buffer -> order preserved across pointer wrap.
